// File: rtl/vita49_pkg.sv
// vita49_pkg: unpacker status bit map, result codes and sequencer state encoding
package vita49_pkg;
   localparam int ST_DONE      = 0;
   localparam int ST_TRAILER   = 1;
   localparam int ST_PKT_TYPE  = 2;
   localparam int ST_CLASS_ID  = 3;
   localparam int ST_STRM_ID   = 4;
   localparam int ST_TSI       = 5;
   localparam int ST_TSF       = 6;
   localparam int ST_PKT_CNT   = 7;
   localparam int ST_OVERRUN   = 8;
   localparam int ST_UNDERRUN  = 9;
   localparam int ST_TLAST     = 10;
   localparam int ST_PKT_SIZE  = 11;

   localparam logic [1:0] RES_DONE  = 2'd0;
   localparam logic [1:0] RES_ERR   = 2'd1;
   localparam logic [1:0] RES_TMO   = 2'd2;
   localparam logic [1:0] RES_ABORT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RST,
      S_ARM,
      S_RUN,
      S_REPORT
   } seq_state_t;
endpackage

// File: rtl/vita49_job_fifo.sv
// vita49_job_fifo: synchronous job FIFO with asynchronously reset pointers
module vita49_job_fifo #(
   parameter int AW = 3,
   parameter int W  = 72
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int DEPTH = 2 ** AW;

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   cnt;

   assign full  = cnt == (AW + 1)'(DEPTH);
   assign empty = cnt == '0;
   assign dout  = mem[rd_ptr];

   // entry storage; only the pointers are reset, so stale contents are never visible
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= din;
   end

   // pointers and occupancy; a push and pop in the same cycle leave the count unchanged
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + (AW + 1)'(push) - (AW + 1)'(pop);
      end
   end
endmodule

// File: rtl/vita49_unpack_seq.sv
// vita49_unpack_seq: queues unpack jobs and runs each through reset/arm/run/report on the unpacker
module vita49_unpack_seq
   import vita49_pkg::*;
#(
   parameter int JOB_AW  = 3,
   parameter int TAG_W   = 8,
   parameter int RST_CYC = 4,
   parameter int TMO_W   = 32
) (
   input  logic             AXIS_ACLK,
   input  logic             AXIS_ARESETN,
   input  logic             job_valid,
   output logic             job_ready,
   input  logic [31:0]      job_stream_id,
   input  logic [31:0]      job_words,
   input  logic [TAG_W-1:0] job_tag,
   input  logic             cfg_enable,
   input  logic             cfg_passthrough,
   input  logic [TMO_W-1:0] cfg_timeout,
   input  logic             abort,
   output logic [31:0]      unp_ctrl,
   output logic [31:0]      unp_stream_id,
   output logic [31:0]      unp_words,
   input  logic [31:0]      unp_status,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [TAG_W-1:0] res_tag,
   output logic [11:0]      res_status,
   output logic [1:0]       res_code,
   output logic             busy,
   output logic             err_sticky,
   output logic [15:0]      jobs_done_cnt,
   output logic [15:0]      jobs_err_cnt
);
   localparam int FW = 64 + TAG_W;
   localparam int RW = $clog2(RST_CYC);
   localparam logic [RW-1:0] RST_LAST = RW'(RST_CYC - 1);

   seq_state_t       state;
   logic [RW-1:0]    rst_cnt;
   logic [TMO_W-1:0] tmo_cnt;
   logic             reset_cmd;
   logic             start_cmd;
   logic [TAG_W-1:0] cur_tag;
   logic [FW-1:0]    head;
   logic             fifo_full;
   logic             fifo_empty;
   logic             launch;
   logic             kill;
   logic             first_run;
   logic             run_err;
   logic             run_done;
   logic             run_tmo;
   logic [1:0]       run_code;
   logic             unused_status;

   assign launch    = state == S_IDLE && !fifo_empty && cfg_enable && !cfg_passthrough;
   assign job_ready = !fifo_full || launch;
   assign kill      = abort && (state == S_RST || state == S_ARM || state == S_RUN);
   assign first_run = tmo_cnt == '0;
   assign run_err   = !first_run && |unp_status[ST_PKT_SIZE:ST_TRAILER];
   assign run_done  = !first_run && unp_status[ST_DONE];
   assign run_tmo   = cfg_timeout != '0 && tmo_cnt == cfg_timeout;
   assign run_code  = run_err ? RES_ERR : run_done ? RES_DONE : RES_TMO;
   assign busy      = state != S_IDLE;
   assign unp_ctrl  = {29'b0, cfg_passthrough, reset_cmd, start_cmd};
   assign res_tag   = cur_tag;
   assign unused_status = ^unp_status[31:12];

   vita49_job_fifo #(
      .AW(JOB_AW),
      .W (FW)
   ) u_fifo (
      .clk  (AXIS_ACLK),
      .rst_n(AXIS_ARESETN),
      .push (job_valid && job_ready),
      .pop  (launch),
      .din  ({job_stream_id, job_words, job_tag}),
      .dout (head),
      .full (fifo_full),
      .empty(fifo_empty)
   );

   // job sequencer: unpacker controls, result record and counters are all registered here
   always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
      if (!AXIS_ARESETN) begin
         state         <= S_IDLE;
         rst_cnt       <= '0;
         tmo_cnt       <= '0;
         reset_cmd     <= 1'b0;
         start_cmd     <= 1'b0;
         unp_stream_id <= '0;
         unp_words     <= '0;
         cur_tag       <= '0;
         res_valid     <= 1'b0;
         res_status    <= '0;
         res_code      <= '0;
         err_sticky    <= 1'b0;
         jobs_done_cnt <= '0;
         jobs_err_cnt  <= '0;
      end else if (kill) begin
         state      <= S_REPORT;
         reset_cmd  <= 1'b1;
         start_cmd  <= 1'b0;
         res_valid  <= 1'b1;
         res_code   <= RES_ABORT;
         res_status <= unp_status[11:0];
      end else begin
         case (state)
            S_IDLE: begin
               if (launch) begin
                  {unp_stream_id, unp_words, cur_tag} <= head;
                  if (head[TAG_W +: 32] == '0) begin
                     state      <= S_REPORT;
                     res_valid  <= 1'b1;
                     res_code   <= RES_ABORT;
                     res_status <= '0;
                  end else begin
                     state     <= S_RST;
                     reset_cmd <= 1'b1;
                     rst_cnt   <= '0;
                  end
               end
            end
            S_RST: begin
               if (rst_cnt == RST_LAST) begin
                  state     <= S_ARM;
                  reset_cmd <= 1'b0;
                  start_cmd <= 1'b1;
               end else begin
                  rst_cnt <= rst_cnt + RW'(1);
               end
            end
            S_ARM: begin
               state     <= S_RUN;
               start_cmd <= 1'b0;
               tmo_cnt   <= '0;
            end
            S_RUN: begin
               tmo_cnt <= tmo_cnt + TMO_W'(1);
               if (run_err || run_done || run_tmo) begin
                  state      <= S_REPORT;
                  res_valid  <= 1'b1;
                  res_code   <= run_code;
                  res_status <= unp_status[11:0];
               end
            end
            S_REPORT: begin
               reset_cmd <= 1'b0;
               if (res_valid && res_ready) begin
                  res_valid <= 1'b0;
                  state     <= S_IDLE;
                  if (res_code == RES_DONE) begin
                     jobs_done_cnt <= jobs_done_cnt + 16'd1;
                  end else begin
                     jobs_err_cnt <= jobs_err_cnt + 16'd1;
                     err_sticky   <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_vita49_unpack_seq.sv
// tb_vita49_unpack_seq: directed jobs against a small unpacker model, results checked by a scoreboard
module tb_vita49_unpack_seq;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        job_valid = 1'b0;
   logic        job_ready;
   logic [31:0] job_stream_id = '0;
   logic [31:0] job_words = '0;
   logic [7:0]  job_tag = '0;
   logic        cfg_enable = 1'b1;
   logic        cfg_passthrough = 1'b0;
   logic [31:0] cfg_timeout = '0;
   logic        abort = 1'b0;
   logic [31:0] unp_ctrl;
   logic [31:0] unp_stream_id;
   logic [31:0] unp_words;
   logic [31:0] unp_status;
   logic        res_valid;
   logic        res_ready = 1'b1;
   logic [7:0]  res_tag;
   logic [11:0] res_status;
   logic [1:0]  res_code;
   logic        busy;
   logic        err_sticky;
   logic [15:0] jobs_done_cnt;
   logic [15:0] jobs_err_cnt;

   always #5 clk = ~clk;

   vita49_unpack_seq dut (
      .AXIS_ACLK      (clk),
      .AXIS_ARESETN   (rst_n),
      .job_valid      (job_valid),
      .job_ready      (job_ready),
      .job_stream_id  (job_stream_id),
      .job_words      (job_words),
      .job_tag        (job_tag),
      .cfg_enable     (cfg_enable),
      .cfg_passthrough(cfg_passthrough),
      .cfg_timeout    (cfg_timeout),
      .abort          (abort),
      .unp_ctrl       (unp_ctrl),
      .unp_stream_id  (unp_stream_id),
      .unp_words      (unp_words),
      .unp_status     (unp_status),
      .res_valid      (res_valid),
      .res_ready      (res_ready),
      .res_tag        (res_tag),
      .res_status     (res_status),
      .res_code       (res_code),
      .busy           (busy),
      .err_sticky     (err_sticky),
      .jobs_done_cnt  (jobs_done_cnt),
      .jobs_err_cnt   (jobs_err_cnt)
   );

   typedef struct {
      logic [7:0]  tag;
      logic [1:0]  code;
      logic [11:0] st;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int n_vec = 0, n_bad = 0, m_vec = 0, m_bad = 0;
   int exp_done = 0, exp_err = 0;
   int cyc = 0, start_cnt = 0, start_cyc = 0, rv_cyc = 0;
   int rst_run = 0, last_rst_len = 0, rst_pulses = 0;
   logic prev_rv = 1'b0, prev_rst = 1'b0;

   // unpacker model: status cleared by reset_cmd, response posted dly cycles after start (dly 0 = silent)
   logic [31:0] resp = 32'h1;
   int dly = 80;
   logic mact;
   int mcnt;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         unp_status <= '0;
         mact <= 1'b0;
         mcnt <= 0;
      end else if (unp_ctrl[1]) begin
         unp_status <= '0;
         mact <= 1'b0;
      end else if (unp_ctrl[0]) begin
         mact <= 1'b1;
         mcnt <= 1;
      end else if (mact) begin
         mcnt <= mcnt + 1;
         if (dly != 0 && mcnt == dly) begin
            unp_status <= resp;
            mact <= 1'b0;
         end
      end
   end

   // monitor: pulse bookkeeping and scoreboard compare on every result handshake
   always @(negedge clk) begin
      cyc++;
      if (unp_ctrl[0]) begin
         start_cnt++;
         start_cyc = cyc;
      end
      if (unp_ctrl[1] && !prev_rst) rst_pulses++;
      if (unp_ctrl[1]) rst_run++;
      else if (rst_run != 0) begin
         last_rst_len = rst_run;
         rst_run = 0;
      end
      prev_rst = unp_ctrl[1];
      if (res_valid && !prev_rv) rv_cyc = cyc;
      prev_rv = res_valid;
      if (res_valid && res_ready) begin
         m_vec++;
         if (sb.size() == 0) begin
            m_bad++;
            $display("FAIL res_unexpected: got tag %0d code %0d status 0x%03h, required no result", res_tag, res_code, res_status);
         end else begin
            e = sb.pop_front();
            if (res_tag !== e.tag || res_code !== e.code || res_status !== e.st) begin
               m_bad++;
               $display("FAIL res_record: got tag %0d code %0d status 0x%03h, required tag %0d code %0d status 0x%03h",
                        res_tag, res_code, res_status, e.tag, e.code, e.st);
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_vec++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   task automatic expect_res(input logic [7:0] tag, input logic [1:0] code, input logic [11:0] st);
      exp_t x;
      x.tag = tag;
      x.code = code;
      x.st = st;
      sb.push_back(x);
      if (code == 2'd0) exp_done++;
      else exp_err++;
   endtask

   task automatic push_job(input logic [31:0] id, input logic [31:0] w, input logic [7:0] tag);
      int n = 0;
      job_valid = 1'b1;
      job_stream_id = id;
      job_words = w;
      job_tag = tag;
      @(negedge clk);
      while (!job_ready && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (!job_ready) begin
         n_vec++;
         n_bad++;
         $display("FAIL push_%0d: job_ready 0 after %0d cycles, required 1", tag, n);
      end
      tick();
      job_valid = 1'b0;
   endtask

   task automatic wait_start(input int lim);
      int n = 0;
      @(negedge clk);
      while (!unp_ctrl[0] && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk("start_seen", {31'b0, unp_ctrl[0]}, 32'h1);
      tick();
   endtask

   task automatic drain(input string name, input int lim);
      int n = 0;
      while (sb.size() != 0 && n < lim) begin
         @(negedge clk);
         n++;
      end
      chk(name, sb.size(), 0);
      sb.delete();
      tick();
   endtask

   initial begin
      repeat (3) tick();
      chk("rst_job_ready", {31'b0, job_ready}, 32'h1);
      chk("rst_busy", {31'b0, busy}, 32'h0);
      chk("rst_res_valid", {31'b0, res_valid}, 32'h0);
      chk("rst_unp_ctrl", unp_ctrl, 32'h0);
      chk("rst_done_cnt", jobs_done_cnt, 32'h0);
      chk("rst_err_sticky", {31'b0, err_sticky}, 32'h0);
      rst_n = 1'b1;
      tick();

      // single job completing normally
      resp = 32'h1;
      dly = 80;
      expect_res(8'd5, 2'd0, 12'h001);
      push_job(32'h1234, 32'd64, 8'd5);
      drain("single_drain", 500);
      chk("single_done_cnt", jobs_done_cnt, exp_done);
      chk("single_rst_len", last_rst_len, 4);
      chk("single_start_cnt", start_cnt, 1);
      chk("single_latency", rv_cyc - start_cyc, 82);
      chk("single_stream_id", unp_stream_id, 32'h1234);
      chk("single_words", unp_words, 32'd64);

      // stream-ID error reported by the unpacker
      resp = 32'h010;
      dly = 10;
      expect_res(8'd6, 2'd1, 12'h010);
      push_job(32'h99, 32'd16, 8'd6);
      drain("err_drain", 300);
      chk("err_sticky", {31'b0, err_sticky}, 32'h1);
      chk("err_cnt", jobs_err_cnt, exp_err);

      // silent unpacker with a 100-cycle limit
      resp = 32'h0;
      dly = 0;
      cfg_timeout = 32'd100;
      expect_res(8'd7, 2'd2, 12'h000);
      push_job(32'h77, 32'd8, 8'd7);
      drain("tmo_drain", 500);
      chk("tmo_latency", rv_cyc - start_cyc, 102);
      cfg_timeout = 32'd0;

      // passthrough suspends launching and drives ctrl[2]
      cfg_passthrough = 1'b1;
      resp = 32'h1;
      dly = 3;
      expect_res(8'd8, 2'd0, 12'h001);
      push_job(32'h88, 32'd4, 8'd8);
      repeat (10) tick();
      chk("pt_busy", {31'b0, busy}, 32'h0);
      chk("pt_unp_ctrl", unp_ctrl, 32'h4);
      cfg_passthrough = 1'b0;
      drain("pt_drain", 300);

      // back-pressure: nine jobs with the result consumer stalled
      res_ready = 1'b0;
      dly = 2;
      for (int i = 0; i < 9; i++) begin
         expect_res(8'(20 + i), 2'd0, 12'h001);
         push_job(32'h100 + i, 32'd4, 8'(20 + i));
      end
      chk("bp_job_ready", {31'b0, job_ready}, 32'h0);
      for (int n = 0; n < 200 && !res_valid; n++) tick();
      repeat (20) tick();
      chk("bp_res_valid", {31'b0, res_valid}, 32'h1);
      chk("bp_still_full", {31'b0, job_ready}, 32'h0);
      chk("bp_busy", {31'b0, busy}, 32'h1);
      res_ready = 1'b1;
      drain("bp_drain", 1000);
      chk("bp_done_cnt", jobs_done_cnt, exp_done);

      // abort while running
      dly = 0;
      expect_res(8'd30, 2'd3, 12'h000);
      push_job(32'h300, 32'd32, 8'd30);
      wait_start(100);
      repeat (5) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      drain("abort_drain", 100);
      chk("abort_rst_len", last_rst_len, 1);
      chk("abort_err_cnt", jobs_err_cnt, exp_err);

      // zero-word job is rejected without touching the unpacker
      begin
         int s0, r0;
         s0 = start_cnt;
         r0 = rst_pulses;
         expect_res(8'd31, 2'd3, 12'h000);
         push_job(32'h310, 32'd0, 8'd31);
         drain("illegal_drain", 100);
         chk("illegal_no_start", start_cnt - s0, 0);
         chk("illegal_no_reset", rst_pulses - r0, 0);
         chk("illegal_err_cnt", jobs_err_cnt, exp_err);
      end

      // asynchronous reset in the middle of a run drops everything queued
      dly = 0;
      push_job(32'h400, 32'd8, 8'd40);
      push_job(32'h410, 32'd8, 8'd41);
      push_job(32'h420, 32'd8, 8'd42);
      wait_start(100);
      repeat (4) tick();
      rst_n = 1'b0;
      #1;
      chk("arst_unp_ctrl", unp_ctrl, 32'h0);
      chk("arst_busy", {31'b0, busy}, 32'h0);
      chk("arst_job_ready", {31'b0, job_ready}, 32'h1);
      chk("arst_err_sticky", {31'b0, err_sticky}, 32'h0);
      chk("arst_err_cnt", jobs_err_cnt, 32'h0);
      chk("arst_stream_id", unp_stream_id, 32'h0);
      exp_done = 0;
      exp_err = 0;
      tick();
      rst_n = 1'b1;
      tick();
      resp = 32'h1;
      dly = 5;
      expect_res(8'd50, 2'd0, 12'h001);
      push_job(32'h500, 32'd8, 8'd50);
      drain("post_rst_drain", 200);
      repeat (20) tick();
      chk("post_rst_done_cnt", jobs_done_cnt, exp_done);
      chk("post_rst_busy", {31'b0, busy}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec + m_vec, n_bad + m_bad);
      $finish;
   end
endmodule
